// File: rtl/uart_prog_loader.sv
// UART program loader: receives a MAGIC/length/data/checksum frame over 8N1 serial,
// writes 32-bit words into the instruction ROM and releases the core once the image checks out.
module uart_prog_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_W       = 20,
  parameter logic [7:0] MAGIC        = 8'hA5,
  parameter int         TIMEOUT      = 2**20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              rom_wr_en,
  output logic [ADDR_W-1:0] rom_wr_addr,
  output logic [31:0]       rom_wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int                TO_W      = $clog2(TIMEOUT + 1) + 1;
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_byte;
  logic             r_byte_vld;
  logic             r_frame_err;

  state_t           r_state;
  logic [15:0]      r_len;
  logic [ADDR_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [31:0]      r_asm;
  logic [7:0]       r_csum;
  logic [TO_W-1:0]  r_gap_cnt;
  logic             r_rom_wr_en;
  logic [ADDR_W-1:0] r_rom_wr_addr;
  logic [31:0]      r_rom_wr_data;
  logic             r_cpu_rst_n;
  logic             r_busy;
  logic             r_load_done;
  logic             r_load_err;

  // Serial bit engine: synchronise the line, find start bits, sample mid-bit, check stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_byte      <= 8'd0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= uart_rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) r_rx_state <= RX_START;
          else                         r_rx_state <= RX_IDLE;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            // a start bit that is high again at mid-bit was only a glitch
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_state <= RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte     <= r_rx_shift;
              r_byte_vld <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame FSM: length capture, word assembly, ROM writes, checksum and core reset control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= 16'd0;
      r_word_idx    <= '0;
      r_byte_idx    <= 2'd0;
      r_asm         <= 32'd0;
      r_csum        <= 8'd0;
      r_gap_cnt     <= '0;
      r_rom_wr_en   <= 1'b0;
      r_rom_wr_addr <= '0;
      r_rom_wr_data <= 32'd0;
      r_cpu_rst_n   <= 1'b0;
      r_busy        <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_rom_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          r_gap_cnt <= '0;
          if (r_byte_vld && (r_byte == MAGIC)) begin
            r_state     <= S_LEN_LO;
            r_cpu_rst_n <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_busy      <= 1'b1;
            r_word_idx  <= '0;
            r_byte_idx  <= 2'd0;
            r_csum      <= 8'd0;
          end else begin
            r_state <= r_state;
          end
        end
        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
          if (r_frame_err || (!r_byte_vld && (r_gap_cnt == TO_LIMIT))) begin
            r_state     <= S_ERR;
            r_busy      <= 1'b0;
            r_load_err  <= 1'b1;
            r_cpu_rst_n <= 1'b0;
          end else if (r_byte_vld) begin
            r_gap_cnt <= '0;
            case (r_state)
              S_LEN_LO: begin
                r_len[7:0] <= r_byte;
                r_state    <= S_LEN_HI;
              end
              S_LEN_HI: begin
                r_len[15:8] <= r_byte;
                r_state     <= ({r_byte, r_len[7:0]} == 16'd0) ? S_CSUM : S_DATA;
              end
              S_DATA: begin
                r_asm      <= {r_byte, r_asm[31:8]};
                r_csum     <= r_csum ^ r_byte;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                  r_rom_wr_en   <= 1'b1;
                  r_rom_wr_addr <= r_word_idx;
                  r_rom_wr_data <= {r_byte, r_asm[31:8]};
                  r_word_idx    <= r_word_idx + ADDR_W'(1);
                  if (r_word_idx[15:0] == (r_len - 16'd1)) r_state <= S_CSUM;
                  else                                     r_state <= S_DATA;
                end else begin
                  r_state <= S_DATA;
                end
              end
              S_CSUM: begin
                r_busy <= 1'b0;
                if (r_byte == r_csum) begin
                  r_state     <= S_RUN;
                  r_cpu_rst_n <= 1'b1;
                  r_load_done <= 1'b1;
                end else begin
                  r_state    <= S_ERR;
                  r_load_err <= 1'b1;
                end
              end
              default: r_state <= S_ERR;
            endcase
          end else begin
            r_gap_cnt <= r_gap_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign rom_wr_en   = r_rom_wr_en;
  assign rom_wr_addr = r_rom_wr_addr;
  assign rom_wr_data = r_rom_wr_data;
  assign cpu_rst_n   = r_cpu_rst_n;
  assign busy        = r_busy;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: serial frames with hand-computed ROM writes and status.
module tb_uart_prog_loader;
  localparam int CPB     = 16;
  localparam int TIMEOUT = 400;
  localparam int ADDR_W  = 20;

  logic              clk;
  logic              rst_n;
  logic              uart_rx;
  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [31:0]       rom_wr_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              load_done;
  logic              load_err;

  int total;
  int bad;
  int wr_cnt;
  logic [ADDR_W-1:0] wr_addr_log [0:63];
  logic [31:0]       wr_data_log [0:63];

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .MAGIC       (8'hA5),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .rom_wr_en  (rom_wr_en),
    .rom_wr_addr(rom_wr_addr),
    .rom_wr_data(rom_wr_data),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every ROM write strobe; a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (rom_wr_en && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] = rom_wr_addr;
      wr_data_log[wr_cnt] = rom_wr_data;
    end
    if (rom_wr_en) wr_cnt = wr_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_t1_frame(input logic [7:0] csum);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hA0, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(csum, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({rom_wr_en, rom_wr_addr, rom_wr_data, cpu_rst_n, busy, load_done, load_err} !== {1'b0, 20'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got en=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b", rom_wr_en, rom_wr_addr, rom_wr_data, cpu_rst_n, busy, load_done, load_err);
    end
  endtask

  task automatic test_good_load();
    int base;
    base = wr_cnt;
    send_t1_frame(8'h20);
    total++;
    if (wr_cnt - base !== 2) begin bad++; $display("FAIL good_wr_count got %0d exp 2", wr_cnt - base); end
    total++;
    if (wr_addr_log[base] !== 20'd0 || wr_data_log[base] !== 32'h00000013) begin
      bad++; $display("FAIL good_wr0 got %h/%h exp 00000/00000013", wr_addr_log[base], wr_data_log[base]);
    end
    total++;
    if (wr_addr_log[base+1] !== 20'd1 || wr_data_log[base+1] !== 32'h00A00093) begin
      bad++; $display("FAIL good_wr1 got %h/%h exp 00001/00a00093", wr_addr_log[base+1], wr_data_log[base+1]);
    end
    total++;
    if ({load_done, cpu_rst_n, load_err, busy} !== 4'b1100) begin
      bad++; $display("FAIL good_status got done,crst,err,busy=%b exp 1100", {load_done, cpu_rst_n, load_err, busy});
    end
    total++;
    if (rom_wr_addr !== 20'd1) begin bad++; $display("FAIL addr_hold got %h exp 00001", rom_wr_addr); end
  endtask

  task automatic test_bad_csum();
    int base;
    base = wr_cnt;
    send_t1_frame(8'h21);
    total++;
    if (wr_cnt - base !== 2) begin bad++; $display("FAIL badcsum_wr_count got %0d exp 2", wr_cnt - base); end
    total++;
    if ({load_err, cpu_rst_n, load_done, busy} !== 4'b1000) begin
      bad++; $display("FAIL badcsum_status got err,crst,done,busy=%b exp 1000", {load_err, cpu_rst_n, load_done, busy});
    end
  endtask

  task automatic test_frame_err();
    int base;
    base = wr_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if ({load_err, cpu_rst_n, busy} !== 3'b100 || wr_cnt != base) begin
      bad++; $display("FAIL frame_err got err,crst,busy=%b writes=%0d exp 100 writes=0", {load_err, cpu_rst_n, busy}, wr_cnt - base);
    end
    base = wr_cnt;
    send_t1_frame(8'h20);
    total++;
    if ({load_done, cpu_rst_n, load_err} !== 3'b110 || wr_cnt - base != 2) begin
      bad++; $display("FAIL recover got done,crst,err=%b writes=%0d exp 110 writes=2", {load_done, cpu_rst_n, load_err}, wr_cnt - base);
    end
  endtask

  task automatic test_timeout_and_empty();
    int base;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    repeat (TIMEOUT - 20) @(negedge clk);
    total++;
    if ({busy, load_err} !== 2'b10) begin bad++; $display("FAIL before_timeout got busy,err=%b exp 10", {busy, load_err}); end
    repeat (40) @(negedge clk);
    total++;
    if ({busy, load_err, cpu_rst_n} !== 3'b010) begin
      bad++; $display("FAIL timeout got busy,err,crst=%b exp 010", {busy, load_err, cpu_rst_n});
    end
    base = wr_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if ({load_done, cpu_rst_n, load_err} !== 3'b110 || wr_cnt != base) begin
      bad++; $display("FAIL empty_image got done,crst,err=%b writes=%0d exp 110 writes=0", {load_done, cpu_rst_n, load_err}, wr_cnt - base);
    end
  endtask

  task automatic test_idle_noise();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h5A, 1'b1);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if ({busy, load_done, load_err, cpu_rst_n} !== 4'b0000 || wr_cnt != base) begin
      bad++; $display("FAIL idle_noise got busy,done,err,crst=%b writes=%0d exp 0000 writes=0", {busy, load_done, load_err, cpu_rst_n}, wr_cnt - base);
    end
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if ({load_done, cpu_rst_n} !== 2'b11) begin bad++; $display("FAIL after_glitch got done,crst=%b exp 11", {load_done, cpu_rst_n}); end
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_rst_n, load_done, busy} !== 3'b001) begin
      bad++; $display("FAIL magic_in_run got crst,done,busy=%b exp 001", {cpu_rst_n, load_done, busy});
    end
  endtask

  task automatic test_reset_mid_data();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    total++;
    if (wr_cnt - base !== 1 || wr_data_log[base] !== 32'h44332211) begin
      bad++; $display("FAIL pre_reset_word got writes=%0d data=%h exp 1/44332211", wr_cnt - base, wr_data_log[base]);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({rom_wr_en, rom_wr_addr, rom_wr_data, cpu_rst_n, busy, load_done, load_err} !== {1'b0, 20'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got en=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b", rom_wr_en, rom_wr_addr, rom_wr_data, cpu_rst_n, busy, load_done, load_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = wr_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (wr_cnt - base !== 1 || wr_addr_log[base] !== 20'd0 || wr_data_log[base] !== 32'h12345678) begin
      bad++; $display("FAIL reload_after_reset got writes=%0d %h/%h exp 1 00000/12345678", wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
    end
    total++;
    if ({load_done, cpu_rst_n} !== 2'b11) begin bad++; $display("FAIL reload_status got done,crst=%b exp 11", {load_done, cpu_rst_n}); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    wr_cnt  = 0;
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_good_load();
    test_bad_csum();
    test_frame_err();
    test_timeout_and_empty();
    test_idle_noise();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
